// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port synchronous RAM with registered read and a clear sequencer
// Optional per-word even parity when RAM_PARITY_EN is defined.
module ram_sync_clr #(
    parameter int unsigned       DATA_W   = 10,
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              select_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              rd_valid_o,
    output logic              addr_err_o,
    output logic              parity_err_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  cnt_d;
    logic              ready_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              addr_err_q;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              access;
    logic              in_range;
    logic              acc_wr;
    logic              acc_rd;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] rd_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Accesses are only honoured once the clear sequence has finished.
    assign access   = (state_q == ST_READY) && select_i;
    assign in_range = {1'b0, address_i} < DEPTH_A;
    assign acc_wr   = access && in_range && write_i;
    assign acc_rd   = access && in_range && !write_i;
    assign idx      = address_i[IDX_W-1:0];
    assign rd_word  = mem_q[idx];
    assign cnt_d    = cnt_q + 1'b1;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = encode(data_in_i);
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = encode(INIT_VAL);
        end else if (acc_wr) begin
            mem_we = 1'b1;
        end
    end

    // The array carries no reset; the clear sequencer establishes its contents.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rd_valid_q <= 1'b0;
                    addr_err_q <= 1'b0;
                    cnt_q      <= cnt_d;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_READY: begin
                    rd_valid_q <= acc_rd;
                    addr_err_q <= access && !in_range;
                    if (acc_rd) begin
                        data_out_q <= rd_word[DATA_W-1:0];
                    end
                    // The access at this edge still completes; the fill starts next edge.
                    if (clear_i) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= acc_rd && (^rd_word);
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign ready_o    = ready_q;
    assign data_out_o = data_out_q;
    assign rd_valid_o = rd_valid_q;
    assign addr_err_o = addr_err_q;

`ifndef SYNTHESIS
    a_strobe_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(rd_valid_q && addr_err_q));
    a_ready_state: assert property (@(posedge clk_i) disable iff (!reset_ni)
        ready_q == (state_q == ST_READY));
`endif

endmodule
